// File: rtl/ingress_frame_queue.sv
// ingress_frame_queue: store-and-forward frame buffer with atomic drop and one-hot arbiter request
module ingress_frame_queue #(
  parameter int NUM_PORTS  = 3,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2048,
  parameter int DESC_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DATA_WIDTH-1:0]         rx_data_i,
  input  logic                          rx_valid_i,
  input  logic                          rx_sof_i,
  input  logic                          rx_eof_i,
  input  logic [NUM_PORTS-1:0]          rx_dest_i,
  input  logic [NUM_PORTS-1:0]          grant_i,
  output logic [NUM_PORTS-1:0]          request_o,
  output logic [DATA_WIDTH-1:0]         tx_data_o,
  output logic                          tx_valid_o,
  output logic                          tx_eof_o,
  output logic                          drop_o,
  output logic [$clog2(DESC_DEPTH):0]   frame_count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int DW = $clog2(DESC_DEPTH);
  localparam logic [PW-1:0] P_DEPTH  = PW'(DEPTH);
  localparam logic [DW:0]   P_DDEPTH = (DW+1)'(DESC_DEPTH);
  typedef enum logic [1:0] {W_IDLE, W_RECV, W_DISC} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_SEND} rstate_t;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [NUM_PORTS-1:0]  r_desc_dest [DESC_DEPTH];
  logic [PW-1:0]         r_desc_len [DESC_DEPTH];
  logic [PW-1:0]         r_wr_ptr, r_wr_tent, r_rd_ptr, r_beat;
  logic [DW:0]           r_dwr, r_drd;
  logic [NUM_PORTS-1:0]  r_dest, r_req;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_tx_valid, r_tx_eof, r_drop;
  wstate_t               r_ws, w_ws_nxt;
  rstate_t               r_rs, w_rs_nxt;
  logic                  w_start, w_cont, w_eof, w_bad, w_full, w_dfull, w_gnt;
  logic                  w_accept, w_commit, w_drop, w_issue, w_last;
  logic [PW-1:0]         w_base, w_head_len;
  logic [NUM_PORTS-1:0]  w_head_dest;
  logic [AW-1:0]         w_rd_addr;
  // a sof seen outside DISC always restarts at the committed pointer
  assign w_start       = rx_valid_i & rx_sof_i & (r_ws != W_DISC);
  assign w_cont        = rx_valid_i & ~rx_sof_i & (r_ws == W_RECV);
  assign w_eof         = rx_valid_i & rx_eof_i;
  assign w_bad         = w_start & ((rx_dest_i == '0) | ((rx_dest_i & (rx_dest_i - NUM_PORTS'(1))) != '0));
  assign w_base        = w_start ? r_wr_ptr : r_wr_tent;
  assign w_full        = (w_base - r_rd_ptr) == P_DEPTH;
  assign w_dfull       = (r_dwr - r_drd) == P_DDEPTH;
  assign frame_count_o = r_dwr - r_drd;
  assign w_head_dest   = r_desc_dest[r_drd[DW-1:0]];
  assign w_head_len    = r_desc_len[r_drd[DW-1:0]];
  assign w_gnt         = |(grant_i & r_req);
  assign w_rd_addr     = AW'(r_rd_ptr + r_beat);
  assign request_o     = r_req;
  assign tx_data_o     = r_tx_data;
  assign tx_valid_o    = r_tx_valid;
  assign tx_eof_o      = r_tx_eof;
  assign drop_o        = r_drop;
  always_ff @(posedge clk_i)
    r_ws <= rst_i ? W_IDLE : w_ws_nxt;
  always_comb
    w_ws_nxt = (r_ws == W_DISC) ? (w_eof ? W_IDLE : W_DISC) :
               (w_start | w_cont) ? (w_eof ? W_IDLE : w_accept ? W_RECV : W_DISC) : r_ws;
  always_comb begin
    w_accept = (w_start | w_cont) & ~w_bad & ~w_full;
    w_commit = w_accept & w_eof & ~w_dfull;
    w_drop   = (w_start & (r_ws == W_RECV)) | ((w_start | w_cont) & ~w_accept) | (w_accept & w_eof & w_dfull);
  end
  always_ff @(posedge clk_i)
    r_rs <= rst_i ? R_IDLE : w_rs_nxt;
  always_comb
    w_rs_nxt = (r_rs == R_IDLE) ? ((frame_count_o != '0) ? R_REQ : R_IDLE) :
               w_last ? R_IDLE : w_issue ? R_SEND : r_rs;
  always_comb begin
    w_issue = (r_rs != R_IDLE) & w_gnt;
    w_last  = w_issue & (r_beat == w_head_len - PW'(1));
  end
  always_ff @(posedge clk_i) begin
    if (w_accept) r_mem[w_base[AW-1:0]] <= rx_data_i;
    if (w_issue) r_tx_data <= r_mem[w_rd_addr];
    if (w_commit) begin
      r_desc_dest[r_dwr[DW-1:0]] <= w_start ? rx_dest_i : r_dest;
      r_desc_len[r_dwr[DW-1:0]]  <= w_base + PW'(1) - r_wr_ptr;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_wr_tent  <= '0;
      r_rd_ptr   <= '0;
      r_beat     <= '0;
      r_dwr      <= '0;
      r_drd      <= '0;
      r_dest     <= '0;
      r_req      <= '0;
      r_tx_valid <= 1'b0;
      r_tx_eof   <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_wr_tent  <= ((w_accept & ~w_eof) | w_commit) ? w_base + PW'(1) : w_drop ? r_wr_ptr : r_wr_tent;
      r_wr_ptr   <= w_commit ? w_base + PW'(1) : r_wr_ptr;
      r_dest     <= w_start ? rx_dest_i : r_dest;
      r_dwr      <= r_dwr + (DW+1)'(w_commit);
      r_drd      <= r_drd + (DW+1)'(w_last);
      r_rd_ptr   <= w_last ? r_rd_ptr + w_head_len : r_rd_ptr;
      r_beat     <= w_last ? '0 : r_beat + PW'(w_issue);
      r_req      <= (r_rs == R_IDLE && frame_count_o != '0) ? w_head_dest : w_last ? '0 : r_req;
      r_tx_valid <= w_issue;
      r_tx_eof   <= w_last;
      r_drop     <= w_drop;
    end
  end
endmodule
